// File: rtl/spi_pixel_loader.sv
// SPI slave (mode 0, MSB first) that turns 16-bit host frames into frame-RAM
// write strobes: a single pixel write, or a fill of every address with one colour.
module spi_pixel_loader #(
    parameter int ADDR_W      = 10,
    parameter int RGB_W       = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sck,
    input  logic              sdi,
    input  logic              cs_n,
    output logic              we,
    output logic [ADDR_W-1:0] adr_out,
    output logic [RGB_W-1:0]  rgb_out,
    output logic              busy,
    output logic              overrun,
    output logic              frame_err
);
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

    logic [SYNC_STAGES-1:0] r_sck_sync, r_sdi_sync, r_cs_sync;
    logic                   r_sck_prev;
    logic [3:0]             r_bit_cnt;
    logic [15:0]            r_shift;
    logic                   r_done;
    logic                   r_frame_err;
    logic                   r_pend_vld, r_pend_cmd;
    logic [RGB_W-1:0]       r_pend_rgb;
    logic [ADDR_W-1:0]      r_pend_adr;
    logic                   r_overrun;
    state_t                 r_state, w_next;
    logic                   r_fill;
    logic [ADDR_W-1:0]      r_adr;
    logic [RGB_W-1:0]       r_rgb;

    logic w_sck_s, w_sdi_s, w_cs_s, w_sck_rise, w_consume, w_last_adr;

    assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
    assign w_sdi_s    = r_sdi_sync[SYNC_STAGES-1];
    assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck_s & ~r_sck_prev;
    assign w_consume  = (r_state == S_IDLE) && r_pend_vld;
    assign w_last_adr = (r_adr == {ADDR_W{1'b1}});

    // cs_n resets high so the receiver starts deselected
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sck_sync <= '0;
            r_sdi_sync <= '0;
            r_cs_sync  <= '1;
        end else begin
            r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], sck};
            r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], sdi};
            r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sck_prev  <= 1'b0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_sck_prev <= w_sck_s;
            r_done     <= 1'b0;
            if (w_cs_s) begin
                if (r_bit_cnt != 4'd0) r_frame_err <= 1'b1;
                r_bit_cnt <= '0;
            end else if (w_sck_rise) begin
                r_shift   <= {r_shift[14:0], w_sdi_s};
                r_bit_cnt <= r_bit_cnt + 4'd1;
                if (r_bit_cnt == 4'd15) r_done <= 1'b1;
            end
        end
    end

    // One-deep slot; a frame landing on a full, unconsumed slot is dropped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend_vld <= 1'b0;
            r_pend_cmd <= 1'b0;
            r_pend_rgb <= '0;
            r_pend_adr <= '0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_consume) r_pend_vld <= 1'b0;
            if (r_done) begin
                if (!r_pend_vld || w_consume) begin
                    r_pend_vld <= 1'b1;
                    r_pend_cmd <= r_shift[15];
                    r_pend_rgb <= r_shift[10 +: RGB_W];
                    r_pend_adr <= r_shift[ADDR_W-1:0];
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (r_pend_vld) w_next = S_SETUP;
            S_SETUP:  w_next = S_STROBE;
            S_STROBE: w_next = S_HOLD;
            S_HOLD:   w_next = (r_fill && !w_last_adr) ? S_SETUP : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        we   = (r_state == S_STROBE);
        busy = (r_state != S_IDLE) || r_pend_vld;
    end

    // Address/colour move only when leaving IDLE or stepping out of a fill HOLD
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fill <= 1'b0;
            r_adr  <= '0;
            r_rgb  <= '0;
        end else if (w_consume) begin
            r_fill <= r_pend_cmd;
            r_adr  <= r_pend_cmd ? '0 : r_pend_adr;
            r_rgb  <= r_pend_rgb;
        end else if (r_state == S_HOLD && r_fill) begin
            if (w_last_adr) r_fill <= 1'b0;
            else            r_adr  <= r_adr + ADDR_W'(1);
        end
    end

    assign adr_out   = r_adr;
    assign rgb_out   = r_rgb;
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;
endmodule

// File: tb/tb_spi_pixel_loader.sv
// Directed bench for spi_pixel_loader: pixel vector table plus hand sequences
// for latency, fill, overrun, framing error, multi-frame and reset abort.
module tb_spi_pixel_loader;
    localparam int ADDR_W = 10;
    localparam int RGB_W  = 3;
    localparam int NPIX   = 1 << ADDR_W;

    logic              clk = 1'b0, reset_n = 1'b0;
    logic              sck = 1'b0, sdi = 1'b0, cs_n = 1'b1;
    logic              we, busy, overrun, frame_err;
    logic [ADDR_W-1:0] adr_out;
    logic [RGB_W-1:0]  rgb_out;

    spi_pixel_loader #(.ADDR_W(ADDR_W), .RGB_W(RGB_W), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .sck(sck), .sdi(sdi), .cs_n(cs_n),
        .we(we), .adr_out(adr_out), .rgb_out(rgb_out), .busy(busy),
        .overrun(overrun), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef logic [ADDR_W+RGB_W-1:0] wr_t;
    wr_t wlog[$];
    int  n_wide = 0, busy_total = 0;
    logic we_prev = 1'b0;

    always @(negedge clk) begin
        if (we) begin
            wlog.push_back({adr_out, rgb_out});
            if (we_prev) n_wide++;
        end
        we_prev = we;
        if (busy) busy_total++;
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic spi_bit(input logic b);
        @(negedge clk) sdi = b;
        repeat (4) @(negedge clk);
        sck = 1'b1;
        repeat (4) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic spi_start();
        @(negedge clk) cs_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic spi_stop();
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [15:0] f);
        for (int i = 15; i >= 0; i--) spi_bit(f[i]);
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 6000; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk(name, int'(k >= 6000), 0);
        repeat (2) @(negedge clk);
    endtask

    function automatic wr_t entry(input int idx);
        if (idx < wlog.size()) return wlog[idx];
        return '1;
    endfunction

    typedef struct {
        logic [15:0]       frame;
        logic [ADDR_W-1:0] adr;
        logic [RGB_W-1:0]  rgb;
    } vec_t;

    initial begin
        vec_t        vecs[6];
        int          base, bstart, bad, k;
        logic [15:0] f;
        wr_t         e;

        vecs[0] = '{16'h16A5, 10'h2A5, 3'd5};
        vecs[1] = '{16'h1C00, 10'h000, 3'd7};
        vecs[2] = '{16'h03FF, 10'h3FF, 3'd0};
        vecs[3] = '{16'h7BFF, 10'h3FF, 3'd6};
        vecs[4] = '{16'h0001, 10'h001, 3'd0};
        vecs[5] = '{16'h1555, 10'h155, 3'd5};

        repeat (3) @(negedge clk);
        chk("rst_we", int'(we), 0);
        chk("rst_adr", int'(adr_out), 0);
        chk("rst_rgb", int'(rgb_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_flags", int'({overrun, frame_err}), 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Pixel latency, counted in clk edges from the final sck rise
        base = wlog.size();
        f = 16'h16A5;
        spi_start();
        for (int i = 15; i >= 1; i--) spi_bit(f[i]);
        @(negedge clk) sdi = f[0];
        repeat (4) @(negedge clk);
        sck = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (i == 4) chk("lat_adr_before", int'(adr_out), 0);
            if (i == 5) begin
                chk("lat_we_setup", int'(we), 0);
                chk("lat_adr_setup", int'(adr_out), 'h2A5);
                chk("lat_rgb_setup", int'(rgb_out), 5);
            end
            if (i == 6) chk("lat_we_strobe", int'(we), 1);
            if (i == 7) begin
                chk("lat_we_hold", int'(we), 0);
                chk("lat_adr_hold", int'(adr_out), 'h2A5);
            end
        end
        sck = 1'b0;
        spi_stop();
        wait_idle("lat_idle");
        chk("lat_nwr", wlog.size() - base, 1);
        chk("lat_flags", int'({overrun, frame_err}), 0);

        foreach (vecs[v]) begin
            base = wlog.size();
            spi_start();
            send_frame(vecs[v].frame);
            spi_stop();
            wait_idle("vec_idle");
            e = entry(base);
            chk($sformatf("vec%0d_nwr", v), wlog.size() - base, 1);
            chk($sformatf("vec%0d_adr", v), int'(e[RGB_W +: ADDR_W]), int'(vecs[v].adr));
            chk($sformatf("vec%0d_rgb", v), int'(e[RGB_W-1:0]), int'(vecs[v].rgb));
        end
        chk("vec_flags", int'({overrun, frame_err}), 0);

        // Full fill
        base = wlog.size();
        bstart = busy_total;
        spi_start();
        send_frame(16'h8C00);
        spi_stop();
        wait_idle("fill_idle");
        chk("fill_nwr", wlog.size() - base, NPIX);
        bad = 0;
        for (int i = 0; i < NPIX; i++) begin
            e = entry(base + i);
            if (e != {ADDR_W'(i), 3'd3}) bad++;
        end
        chk("fill_order", bad, 0);
        chk("fill_busy_cycles", busy_total - bstart, 3 * NPIX + 1);
        chk("fill_end_adr", int'(adr_out), NPIX - 1);
        chk("fill_end_we", int'(we), 0);

        // Two frames in one select
        base = wlog.size();
        spi_start();
        send_frame(16'h16A5);
        send_frame(16'h1C00);
        spi_stop();
        wait_idle("multi_idle");
        chk("multi_nwr", wlog.size() - base, 2);
        chk("multi_wr0", int'(entry(base)), int'({10'h2A5, 3'd5}));
        chk("multi_wr1", int'(entry(base + 1)), int'({10'h000, 3'd7}));

        // Select released after 9 bits
        base = wlog.size();
        spi_start();
        for (int i = 0; i < 9; i++) spi_bit(1'b1);
        spi_stop();
        repeat (10) @(negedge clk);
        chk("ferr_nwr", wlog.size() - base, 0);
        chk("ferr_flag", int'(frame_err), 1);
        chk("ferr_ovr", int'(overrun), 0);
        spi_start();
        send_frame(16'h16A5);
        spi_stop();
        wait_idle("ferr_idle");
        chk("ferr_recover", int'(entry(base)), int'({10'h2A5, 3'd5}));

        // Pixel queued during fill, then a frame dropped on the full slot
        base = wlog.size();
        spi_start();
        send_frame(16'h8C00);
        spi_stop();
        spi_start();
        send_frame(16'h16A5);
        spi_stop();
        repeat (5) @(negedge clk);
        chk("ovr_busy_mid", int'(busy), 1);
        chk("ovr_flag_pre", int'(overrun), 0);
        spi_start();
        send_frame(16'h0001);
        spi_stop();
        repeat (5) @(negedge clk);
        chk("ovr_flag_post", int'(overrun), 1);
        wait_idle("ovr_idle");
        chk("ovr_nwr", wlog.size() - base, NPIX + 1);
        chk("ovr_last_fill", int'(entry(base + NPIX - 1)), int'({10'h3FF, 3'd3}));
        chk("ovr_pixel", int'(entry(base + NPIX)), int'({10'h2A5, 3'd5}));

        // Reset mid-fill
        spi_start();
        send_frame(16'h8C00);
        spi_stop();
        for (k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (adr_out == 10'd100) break;
        end
        chk("rst_fill_reach100", int'(k >= 2000), 0);
        reset_n = 1'b0;
        #1;
        base = wlog.size();
        chk("rst_fill_we", int'(we), 0);
        chk("rst_fill_adr", int'(adr_out), 0);
        chk("rst_fill_rgb", int'(rgb_out), 0);
        chk("rst_fill_busy", int'(busy), 0);
        chk("rst_fill_flags", int'({overrun, frame_err}), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("rst_fill_nwr", wlog.size() - base, 0);
        chk("rst_fill_idle", int'(busy), 0);

        chk("we_width", n_wide, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
